// File: rtl/serial_shift_unit_pkg.sv
// Shared constants for the serial shift unit: opcodes, FSM states, datapath width.
package serial_shift_unit_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 4;

    localparam logic [1:0] OP_SHL = 2'd0;
    localparam logic [1:0] OP_SHR = 2'd1;
    localparam logic [1:0] OP_ROL = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_shift_unit_step.sv
// One-bit combinational shift/rotate step used by the serial shift unit.
module shift_step_16
    import serial_shift_unit_pkg::*;
(
    input  logic [15:0] value,
    input  logic [1:0]  op,
    output logic [15:0] next_value,
    output logic        out_bit
);

    // Select the single-bit transformation and the bit that leaves the word
    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (op)
            OP_SHL: begin
                next_value = {value[14:0], 1'b0};
                out_bit    = value[15];
            end
            OP_SHR: begin
                next_value = {1'b0, value[15:1]};
                out_bit    = value[0];
            end
            OP_ROL: begin
                next_value = {value[14:0], value[15]};
                out_bit    = value[15];
            end
            OP_ROR: begin
                next_value = {value[0], value[15:1]};
                out_bit    = value[0];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_shift_unit.sv
// Multi-cycle 16-bit shifter: one single-bit step per clock, done pulse on completion.
module serial_shift_unit
    import serial_shift_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] count_r, next_count_s;
    logic [1:0]       op_r, next_op_s;
    logic [WIDTH-1:0] result_r, next_result_s;
    logic             carry_r, next_carry_s;
    logic             busy_r, done_r;
    logic [WIDTH-1:0] step_value_s;
    logic             step_bit_s;

    shift_step_16 u_step (
        .value      (result_r),
        .op         (op_r),
        .next_value (step_value_s),
        .out_bit    (step_bit_s)
    );

    // Next-state, counter and datapath update logic
    always_comb begin
        next_state_s  = state_r;
        next_count_s  = count_r;
        next_op_s     = op_r;
        next_result_s = result_r;
        next_carry_s  = carry_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_result_s = data_in;
                    next_op_s     = op;
                    next_count_s  = amount;
                    next_carry_s  = 1'b0;
                    next_state_s  = ST_SHIFT;
                end else begin
                    next_state_s  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    next_result_s = step_value_s;
                    next_carry_s  = step_bit_s;
                    next_count_s  = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    next_count_s  = count_r;
                end
                // Zero amount still spends one cycle here so latency is max(amount,1)
                if (count_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            count_r  <= {CNT_W{1'b0}};
            op_r     <= 2'd0;
            result_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            count_r  <= next_count_s;
            op_r     <= next_op_s;
            result_r <= next_result_s;
            carry_r  <= next_carry_s;
            busy_r   <= (next_state_s == ST_SHIFT);
            done_r   <= (next_state_s == ST_DONE);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign carry_out = carry_r;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed self-checking bench for serial_shift_unit.
module tb_serial_shift_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  amount;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;

    int n_vec = 0;
    int n_err = 0;

    serial_shift_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .amount    (amount),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive a start request that is sampled at the next rising edge (E0)
    task automatic start_op(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        op      = o;
        amount  = a;
        data_in = d;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 2'd0;
        amount  = 4'd0;
        data_in = 16'h0000;
    endtask

    // Count busy cycles until done, then check result, carry and pulse width
    task automatic wait_done(input string tag, input int n_exp, input logic [15:0] r_exp,
                             input logic c_exp);
        int busy_cnt = 0;
        logic seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
        chk({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " busy_cycles"}, busy_cnt, n_exp);
        chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, " result"}, {16'd0, result}, {16'd0, r_exp});
        chk({tag, " carry"}, {31'd0, carry_out}, {31'd0, c_exp});
        @(negedge clk);
        chk({tag, " done_pulse_end"}, {31'd0, done}, 32'd0);
        chk({tag, " result_held"}, {16'd0, result}, {16'd0, r_exp});
    endtask

    initial begin
        int done_cnt;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'd0;
        amount  = 4'd0;
        data_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst result", {16'd0, result}, 32'd0);
        chk("rst carry", {31'd0, carry_out}, 32'd0);

        start_op(2'd0, 4'd1, 16'h8001);
        wait_done("shl1", 1, 16'h0002, 1'b1);

        start_op(2'd1, 4'd4, 16'h8001);
        wait_done("shr4", 4, 16'h0800, 1'b0);

        start_op(2'd3, 4'd1, 16'h0001);
        wait_done("ror1", 1, 16'h8000, 1'b1);

        start_op(2'd2, 4'd15, 16'h1234);
        wait_done("rol15", 15, 16'h091A, 1'b0);

        start_op(2'd0, 4'd3, 16'h00F1);
        wait_done("shl3", 3, 16'h0788, 1'b0);

        start_op(2'd2, 4'd0, 16'hBEEF);
        wait_done("amt0", 1, 16'hBEEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("amt0 hold result", {16'd0, result}, 32'h0000BEEF);
            chk("amt0 hold done", {31'd0, done}, 32'd0);
        end

        // Start pulse during SHIFT must be ignored
        start_op(2'd0, 4'd8, 16'h00FF);
        @(negedge clk);
        @(negedge clk);
        op      = 2'd3;
        amount  = 4'd1;
        data_in = 16'hFFFF;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        wait_done("ignore", 6, 16'hFF00, 1'b0);

        // Reset mid-operation aborts with no done pulse
        start_op(2'd0, 4'd8, 16'h00FF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort result", {16'd0, result}, 32'd0);
        chk("abort carry", {31'd0, carry_out}, 32'd0);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("abort no activity", done_cnt, 0);

        start_op(2'd3, 4'd1, 16'h0001);
        wait_done("post_rst", 1, 16'h8000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
